// File: rtl/pipe_register_pkg.sv
// Shared types and helpers for the elastic pipeline register.
// Provides the skid-stage state encoding and the occupancy counter width.
package pipe_register_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Width needed to hold 0..2*depth words.
    function automatic int cnt_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// One skid-buffered pipeline stage: main register plus skid register.
// Ports: i_clk/i_rst/i_flush, upstream i_valid/o_ready/i_data,
// downstream o_valid/i_ready/o_data. o_ready comes straight from state.
module pipe_register_stage
    import pipe_register_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    // Ready depends only on the state register, so no
    // combinational path runs from i_ready back to o_ready.
    assign o_ready  = (state_q != ST_FULL);
    assign o_valid  = (state_q != ST_EMPTY);
    assign o_data   = main_q;
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = i_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_fire && !out_fire) begin
                    skid_d  = i_data;
                    state_d = ST_FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire && out_fire) begin
                    main_d  = i_data;
                end
            end
            ST_FULL: begin
                // Never accepts here; drain promotes the skid word.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else if (i_flush) begin
            // Flush drops occupancy but leaves data untouched.
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH chained skid stages, 2*DEPTH words.
// Ports: i_clk/i_rst/i_flush, upstream i_valid/o_ready/i_data,
// downstream o_valid/i_ready/o_data, occupancy o_count.
module pipe_register
    import pipe_register_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 DEPTH     = 2,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_data,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int CNT_W = cnt_w(DEPTH);

    logic              vld [DEPTH+1];
    logic              rdy [DEPTH+1];
    logic [DATA_W-1:0] dat [DEPTH+1];

    assign vld[0]     = i_valid;
    assign dat[0]     = i_data;
    assign rdy[DEPTH] = i_ready;
    assign o_ready    = rdy[0];
    assign o_valid    = vld[DEPTH];
    assign o_data     = dat[DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_register_stage #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_flush (i_flush),
            .i_valid (vld[g]),
            .o_ready (rdy[g]),
            .i_data  (dat[g]),
            .o_valid (vld[g+1]),
            .i_ready (rdy[g+1]),
            .o_data  (dat[g+1])
        );
    end

    logic             acc;
    logic             drn;
    logic [CNT_W-1:0] count_q, count_d;

    assign acc     = i_valid && o_ready;
    assign drn     = o_valid && i_ready;
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (acc && !drn) begin
            count_d = count_q + CNT_W'(1);
        end else if (!acc && drn) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
Parametrised elastic pipeline register: a DEPTH-stage chain of skid-buffered stages carrying DATA_W-bit words under a valid/ready handshake.
Generalises the plain enable register to arbitrary width, arbitrary depth and full-throughput backpressure, with occupancy reporting and flush.
Used between datapath blocks to break timing paths on both data/valid and ready without losing throughput.

Parameters:
DATA_W, 8, width of data word (>=1)
DEPTH, 2, number of pipeline stages (>=1)
RESET_VAL, '0, value loaded into every data register on reset

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_flush  input  1  synchronous flush, discards all stored words
i_valid  input  1  upstream word valid
o_ready  output  1  block can accept a word this cycle (registered)
i_data  input  DATA_W  upstream word
o_valid  output  1  downstream word valid
i_ready  input  1  downstream accepts
o_data  output  DATA_W  downstream word
o_count  output  CNT_W  words held, CNT_W = $clog2(2*DEPTH+1)

Behaviour:
- One clock; reset is synchronous and active-high: i_clk, i_rst.
- Transfer in: i_valid && o_ready at a rising edge. Transfer out: o_valid && i_ready at a rising edge.
- Reset (i_rst=1 at edge): all stage valids 0, all data regs = RESET_VAL, o_count=0. After the edge: o_valid=0, o_data=RESET_VAL, o_ready=1.
- Priority: i_rst > i_flush > normal operation.
- Each stage is a skid buffer with a main reg and a skid reg, 3 states:
  - EMPTY: accept -> BUSY.
  - BUSY: accept with no output transfer -> FULL (word to skid). Output transfer with no accept -> EMPTY. Both at once -> BUSY (main reloads).
  - FULL: output transfer -> BUSY (skid moves to main). It never accepts in FULL.
- Stage ready = registered (state != FULL). The o_ready input/output of each stage carries no combinational path.
- Capacity is 2*DEPTH words. Order is strictly preserved, with no loss or duplication.
- Latency: an accepted word appears on o_valid DEPTH cycles later when i_ready=1 throughout. Throughput is 1 word/cycle sustained.
- Stability: while o_valid=1 && i_ready=0, o_data and o_valid hold unchanged.
- Backpressure: with i_ready held 0, o_ready drops the cycle after the 2*DEPTH-th accept.
- o_count updates at each edge:
  - +1 on accept only.
  - -1 on output transfer only.
  - unchanged on both or neither.
  - Never exceeds 2*DEPTH and never underflows.
- Flush (i_flush=1 at edge):
  - All stage valids clear; data regs are not cleared.
  - o_count=0, o_ready=1 after the edge.
  - A word offered in the flush cycle is discarded and counted as not accepted.
  - An output transfer in the flush cycle is still consumed by downstream but is the last word out.
- i_valid must not depend on o_ready. o_valid never depends combinationally on i_ready.
- Reset or flush mid-stream: no partial word or stale valid appears afterwards.

Decomposition:
- Package pipe_register_pkg:
  - typedef enum stage_state_e {ST_EMPTY, ST_BUSY, ST_FULL}.
  - function cnt_w(depth) returning $clog2(2*depth+1).
- Sub-module pipe_register_stage:
  - Contains one skid-buffer stage with params DATA_W and RESET_VAL.
  - Ports: i_clk, i_rst, i_flush, plus an in and out handshake.
  - The top level generates DEPTH instances and the o_count counter.

Test Plan:
- Reset (DATA_W=8, DEPTH=2, RESET_VAL=8'h00): hold i_rst 2 cycles with i_valid=1 -> o_valid=0, o_data=8'h00, o_ready=1, o_count=0; no word accepted.
- Streaming: i_ready=1, push 8'h01..8'h10 back-to-back -> first o_valid 2 cycles after first accept, then 8'h01..8'h10 on consecutive cycles; o_ready stays 1; o_count peaks at 2.
- Backpressure: i_ready=0, push 8'hA0.. continuously -> exactly 8'hA0..8'hA3 accepted, o_ready=0, o_count=4, o_data=8'hA0 stable. Release i_ready -> A0,A1,A2,A3 in order; o_ready returns 1 the cycle after first drain.
- Random stall: 1000 random words, i_valid and i_ready each 50% random -> scoreboard shows order preserved, no loss or duplication, o_count equals the model every cycle.
- Flush: 3 words stored, i_flush=1 with i_valid=1, i_data=8'hFF -> next cycle o_valid=0, o_count=0, o_ready=1; 8'hFF never emerges.
- Reset mid-operation: i_rst and i_flush together while FULL -> reset state as in the first scenario, o_data=RESET_VAL.
